nn_argmax: RTL

Downstream stage of the neuron datapath: consumes the 12-bit signed aggregated neuron sums produced by the accumulator, one neuron per accepted transfer. Applies the output activation and tracks the running maximum across a frame of `NUM_NEURONS` outputs. At frame end it reports the winning neuron index and value, which serves as the classification result of the accelerator.

---
 rtl/nn_argmax.sv | 115 +++++++++++
 1 files changed

// File: rtl/nn_argmax.sv
// Output activation and running argmax over a frame of NUM_NEURONS sums.
// Define NN_ARGMAX_RELU_EN for ReLU activation; otherwise identity.
module nn_argmax #(
  parameter int DATA_W      = 12,
  parameter int NUM_NEURONS = 10,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              act_valid,
  output logic [DATA_W-1:0] act_out,
  output logic [IDX_W-1:0]  best_idx,
  output logic [DATA_W-1:0] best_val,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  state_t                    r_state;
  logic [IDX_W-1:0]          r_cnt;
  logic                      r_ready;
  logic                      r_busy;
  logic                      r_act_valid;
  logic signed [DATA_W-1:0]  r_act_out;
  logic [IDX_W-1:0]          r_best_idx;
  logic signed [DATA_W-1:0]  r_best_val;
  logic                      r_done;
  logic signed [DATA_W-1:0]  w_act;
  logic                      w_better;

`ifdef NN_ARGMAX_RELU_EN
  assign w_act = in_data[DATA_W-1] ? '0 : $signed(in_data);
`else
  assign w_act = $signed(in_data);
`endif

  assign w_better = (r_cnt == '0) || (w_act > r_best_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_act_valid <= 1'b0;
      r_act_out   <= '0;
      r_best_idx  <= '0;
      r_best_val  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_act_valid <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          // a restart discards any transfer offered in the same cycle
          if (start) begin
            r_cnt <= '0;
          end else if (in_valid) begin
            r_act_valid <= 1'b1;
            r_act_out   <= w_act;
            if (w_better) begin
              r_best_val <= w_act;
              r_best_idx <= r_cnt;
            end
            if (r_cnt == LAST) begin
              r_state <= S_DONE;
              r_cnt   <= '0;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_ready;
  assign busy      = r_busy;
  assign act_valid = r_act_valid;
  assign act_out   = r_act_out;
  assign best_idx  = r_best_idx;
  assign best_val  = r_best_val;
  assign done      = r_done;

endmodule
